imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 31 +++
 rtl/imem_array.sv | 31 +++
 rtl/imem_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader and the fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_loader_pkg;

    localparam int INS_BYTES = 10;
    localparam int W         = 8 * INS_BYTES;
    localparam int DEPTH     = 16;
    localparam int AW        = $clog2(DEPTH);
    localparam int IDX_W     = $clog2(INS_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    // Opcode bytes used by benches to build programs.
    localparam logic [7:0] HALT = 8'h00;
    localparam logic [7:0] NOP  = 8'h10;

    // Field positions inside a packed instruction word. Fetch splits the
    // word using the same offsets, so packing and decode cannot drift apart.
    localparam int IFUN_LSB  = 0;
    localparam int ICODE_LSB = 4;
    localparam int RB_LSB    = 8;
    localparam int RA_LSB    = 12;
    localparam int VALC_LSB  = 16;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DATA_W x N_WORDS, synchronous write, combinational read.
// Latency: write visible on rdata right after the writing clk edge; read is 0 cycles.
// Backpressure: none; a write is taken every cycle we is high.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata asynchronous read port.
// Contents are deliberately not reset so a reset keeps the loaded program.
module imem_array
    import imem_loader_pkg::*;
#(
    parameter int DATA_W  = W,
    parameter int N_WORDS = DEPTH,
    parameter int ADDR_W  = AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream (10 bytes per word, byte k -> bits [8k+7:8k]) into a 16-word instruction memory.
// Latency: last byte of a word accepted at edge N, word visible on ins after edge N+1.
// Backpressure: in_ready high only in LOAD; one WRITE bubble per word, nothing accepted in IDLE/DONE.
// Ports: clk/reset; start pulse; in_valid/in_byte/in_eof/in_ready byte stream;
//        busy/done/words status; read_addr -> ins combinational fetch read port.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    input  logic          in_eof,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words,
    input  logic [AW-1:0] read_addr,
    output logic [W-1:0]  ins
);

    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(INS_BYTES - 1);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  byte_idx;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      asm_word;
    logic              eof_seen;
    logic              accept;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (byte_idx == LAST_BYTE || in_eof)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                // Stop at the last entry rather than wrapping onto word 0.
                if (eof_seen || wr_addr == LAST_ADDR) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte assembler and write pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            wr_addr  <= '0;
            words    <= '0;
            asm_word <= '0;
            eof_seen <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx <= '0;
                        wr_addr  <= '0;
                        words    <= '0;
                        asm_word <= '0;
                        eof_seen <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int k = 0; k < INS_BYTES; k++) begin
                            if (byte_idx == IDX_W'(k)) begin
                                asm_word[8*k +: 8] <= in_byte;
                            end
                        end
                        if (in_eof) begin
                            eof_seen <= 1'b1;
                        end
                        // On the final byte the index is left alone; WRITE
                        // rewinds it. Bytes never stored stay zero because the
                        // register is cleared after every write.
                        if (byte_idx != LAST_BYTE && !in_eof) begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_addr  <= wr_addr + 1'b1;
                    words    <= words + 1'b1;
                    byte_idx <= '0;
                    asm_word <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    imem_array #(
        .DATA_W  (W),
        .N_WORDS (DEPTH),
        .ADDR_W  (AW)
    ) u_array (
        .clk   (clk),
        .we    (state == WRITE),
        .waddr (wr_addr),
        .wdata (asm_word),
        .raddr (read_addr),
        .rdata (ins)
    );

endmodule
